// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - store size encodings and queued store entry layout
package store_pkg;

    localparam int STORE_AW = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Word address only; the byte offset is carried by be.
    typedef struct packed {
        logic [STORE_AW-3:0] addr;
        logic [31:0]         wdata;
        logic [3:0]          be;
    } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - synchronous FIFO of store entries with flush and occupancy count
module store_fifo
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  store_entry_t             wr_entry,
    output store_entry_t             rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    store_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push;
    logic           do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_entry = mem_q[rd_ptr_q];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; validity lives in count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - narrows/replicates store data onto byte lanes and queues it for D-mem
module store_align_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = STORE_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     st_err,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic [$clog2(DEPTH):0]   count
);

    logic [31:0]  fmt_wdata;
    logic [3:0]   fmt_be;
    logic         fmt_err;
    logic         accept;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         st_err_q, st_err_d;
    store_entry_t wr_entry;
    store_entry_t head;

    always_comb begin
        fmt_wdata = st_data;
        fmt_be    = 4'b0000;
        fmt_err   = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                fmt_wdata = {4{st_data[7:0]}};
                fmt_be    = 4'b0001 << st_addr[1:0];
            end
            SZ_HALF: begin
                fmt_wdata = {2{st_data[15:0]}};
                fmt_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                fmt_err   = st_addr[0];
            end
            SZ_WORD: begin
                fmt_wdata = st_data;
                fmt_be    = 4'b1111;
                fmt_err   = (st_addr[1:0] != 2'b00);
            end
            default: begin
                fmt_err   = 1'b1;
            end
        endcase
    end

    // An errored request still consumes the handshake but never reaches the queue.
    assign accept = st_valid && st_ready;
    assign push   = accept && !fmt_err;
    assign pop    = mem_valid && mem_ready;

    assign wr_entry.addr  = st_addr[AW-1:2];
    assign wr_entry.wdata = fmt_wdata;
    assign wr_entry.be    = fmt_be;

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Derived from the registered count only, so mem_ready never reaches st_ready.
    assign st_ready  = !fifo_full;
    assign mem_valid = !fifo_empty;
    assign mem_addr  = {head.addr, 2'b00};
    assign mem_wdata = head.wdata;
    assign mem_be    = head.be;

    assign st_err_d = accept && fmt_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_err_q <= 1'b0;
        else        st_err_q <= st_err_d;
    end

    assign st_err = st_err_q;

endmodule

// File: tb/tb_store_align_buffer.sv
// tb/tb_store_align_buffer.sv - randomized check of store_align_buffer against a queue model
module tb_store_align_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    store_align_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_err    (st_err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    bit   err_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Lane replication expressed as multiplication by a lane-spread constant.
    function automatic bit model_fmt(input logic [31:0] a, input logic [31:0] d,
                                     input logic [1:0] sz, output ent_t e);
        int lane;
        lane    = int'(a % 4);
        e.addr  = a - 32'(lane);
        e.wdata = d;
        e.be    = 4'd0;
        case (sz)
            2'd0: begin
                e.wdata = (d & 32'hFF) * 32'h01010101;
                e.be    = 4'(1 << lane);
                return 1'b0;
            end
            2'd1: begin
                e.wdata = (d & 32'hFFFF) * 32'h00010001;
                e.be    = (lane >= 2) ? 4'hC : 4'h3;
                return (lane % 2) != 0;
            end
            2'd2: begin
                e.be = 4'hF;
                return lane != 0;
            end
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_count"}, 64'(count), 64'(q.size()));
        chk({tag, "_ready"}, 64'(st_ready), 64'(q.size() < DEPTH));
        chk({tag, "_mvalid"}, 64'(mem_valid), 64'(q.size() > 0));
        chk({tag, "_err"}, 64'(st_err), 64'(err_exp));
        if (q.size() > 0) begin
            chk({tag, "_maddr"}, 64'(mem_addr), 64'(q[0].addr));
            chk({tag, "_wdata"}, 64'(mem_wdata), 64'(q[0].wdata));
            chk({tag, "_be"}, 64'(mem_be), 64'(q[0].be));
        end
    endtask

    // Called at a falling edge: drive, cross one rising edge, update model, check.
    task automatic step(input string tag, input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input bit mr, input bit fl);
        ent_t e;
        bit   is_err, acc, do_pop;
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        st_size   = sz;
        mem_ready = mr;
        flush     = fl;
        is_err = model_fmt(a, d, sz, e);
        acc    = v && (q.size() < DEPTH);
        do_pop = mr && (q.size() > 0);
        @(posedge clk);
        @(negedge clk);
        err_exp = acc && is_err;
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (acc && !is_err) q.push_back(e);
        end
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input bit mr);
        step(tag, 1'b0, 32'h0, 32'h0, 2'd0, mr, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; st_valid = 1'b0; mem_ready = 1'b0;
        st_addr = '0; st_data = '0; st_size = '0;
        err_exp = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // byte store into lane 3
        step("t1", 1'b1, 32'h1003, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0);
        chk("t1_addr_const", 64'(mem_addr), 64'h1000);
        chk("t1_wdata_const", 64'(mem_wdata), 64'hEFEFEFEF);
        chk("t1_be_const", 64'(mem_be), 64'b1000);
        idle("t1_drain", 1'b1);

        // upper half, then misaligned half
        step("t2", 1'b1, 32'h2002, 32'h12345678, 2'd1, 1'b0, 1'b0);
        chk("t2_wdata_const", 64'(mem_wdata), 64'h56785678);
        chk("t2_be_const", 64'(mem_be), 64'b1100);
        idle("t2_drain", 1'b1);
        step("t2_mis", 1'b1, 32'h2001, 32'h12345678, 2'd1, 1'b0, 1'b0);
        chk("t2_err_const", 64'(st_err), 64'd1);
        chk("t2_count_const", 64'(count), 64'd0);
        idle("t2_errclr", 1'b0);
        chk("t2_err_pulse", 64'(st_err), 64'd0);

        // fill, hold, drain in order
        for (int i = 0; i < 4; i++)
            step("t3_fill", 1'b1, 32'h3000 + 32'(4 * i), 32'hA0 + 32'(i), 2'd2, 1'b0, 1'b0);
        chk("t3_full_count", 64'(count), 64'd4);
        chk("t3_full_ready", 64'(st_ready), 64'd0);
        step("t3_held", 1'b1, 32'h3010, 32'hBB, 2'd2, 1'b0, 1'b0);
        // full + pop + push same cycle: push refused
        step("t4_fullpop", 1'b1, 32'h3010, 32'hBB, 2'd2, 1'b1, 1'b0);
        chk("t4_count3", 64'(count), 64'd3);
        idle("t4_pop", 1'b1);
        step("t4_pushpop", 1'b1, 32'h3020, 32'hCC, 2'd2, 1'b1, 1'b0);
        chk("t4_count2", 64'(count), 64'd2);
        for (int i = 0; i < 3; i++) idle("t3_drain", 1'b1);

        // streaming across pointer wrap
        for (int i = 0; i < 10; i++)
            step("t5", 1'b1, 32'h5000 + 32'(4 * i), $urandom, 2'd2, 1'(i % 2), 1'b0);
        for (int i = 0; i < 8; i++) idle("t5_drain", 1'b1);

        // flush with 3 queued, errored request in the flush cycle
        for (int i = 0; i < 3; i++)
            step("t6_fill", 1'b1, 32'h6000 + 32'(i), $urandom, 2'd0, 1'b0, 1'b0);
        step("t6_flush", 1'b1, 32'h6001, 32'h1, 2'd2, 1'b1, 1'b1);
        chk("t6_flush_count", 64'(count), 64'd0);
        chk("t6_flush_err", 64'(st_err), 64'd1);
        idle("t6_post", 1'b0);

        // async reset mid-drain
        for (int i = 0; i < 3; i++)
            step("t6_refill", 1'b1, 32'h7000 + 32'(4 * i), $urandom, 2'd2, 1'b0, 1'b0);
        mem_ready = 1'b1;
        st_valid  = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_mvalid", 64'(mem_valid), 64'd0);
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_ready", 64'(st_ready), 64'd1);
        q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs("t6_rst");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = 32'h8000 + 32'($urandom_range(0, 255));
            step("rnd", 1'($urandom_range(0, 3) != 0), a, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 6; i++) idle("rnd_drain", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
